// File: rtl/alu_issue_pkg.sv
// alu_issue_pkg: default widths, ALU opcodes and issue FSM state encoding
package alu_issue_pkg;
  localparam int DEF_WORD_SIZE = 16;
  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_REG_BITS = 3;
  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_MUL = 3'd2,
    ALU_SLT = 3'd3,
    ALU_AND = 3'd4,
    ALU_OR = 3'd5,
    ALU_XOR = 3'd6,
    ALU_SHIFT = 3'd7
  } alu_op_e;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WRITE = 2'd2
  } state_e;
endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: issue-stage bus bundling the instruction handshake, ALU drive/result, writeback and debug read
//   slave  = the issue stage (alu_issue); master = front end + ALU + debug observer
interface alu_issue_if import alu_issue_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int REG_BITS = DEF_REG_BITS
);
  logic instr_valid;
  logic instr_ready;
  logic [2:0] instr_op;
  logic [REG_BITS-1:0] instr_rd;
  logic [REG_BITS-1:0] instr_rs1;
  logic [REG_BITS-1:0] instr_rs2;
  logic instr_use_imm;
  logic [WORD_SIZE-1:0] instr_imm;
  logic [2:0] alu_op;
  logic [WORD_SIZE-1:0] alu_in1;
  logic [WORD_SIZE-1:0] alu_in2;
  logic alu_enable;
  logic [WORD_SIZE-1:0] alu_out;
  logic wb_valid;
  logic [REG_BITS-1:0] wb_rd;
  logic [WORD_SIZE-1:0] wb_data;
  logic [REG_BITS-1:0] dbg_addr;
  logic [WORD_SIZE-1:0] dbg_data;
  modport slave (
    input instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_use_imm, instr_imm, alu_out, dbg_addr,
    output instr_ready, alu_op, alu_in1, alu_in2, alu_enable, wb_valid, wb_rd, wb_data, dbg_data
  );
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_use_imm, instr_imm, alu_out, dbg_addr,
    input instr_ready, alu_op, alu_in1, alu_in2, alu_enable, wb_valid, wb_rd, wb_data, dbg_data
  );
endinterface

// File: rtl/alu_regfile.sv
// alu_regfile: register file with two operand read ports, a debug read port, one sync write port; r0 reads 0
//   clk/reset, we_i/waddr_i/wdata_i write, raddr1_i/raddr2_i -> rdata1_o/rdata2_o, dbg_addr_i -> dbg_data_o
module alu_regfile #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS = 8,
  parameter int REG_BITS = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic we_i,
  input  logic [REG_BITS-1:0] waddr_i,
  input  logic [WORD_SIZE-1:0] wdata_i,
  input  logic [REG_BITS-1:0] raddr1_i,
  output logic [WORD_SIZE-1:0] rdata1_o,
  input  logic [REG_BITS-1:0] raddr2_i,
  output logic [WORD_SIZE-1:0] rdata2_o,
  input  logic [REG_BITS-1:0] dbg_addr_i,
  output logic [WORD_SIZE-1:0] dbg_data_o
);
  logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
  always_ff @(posedge clk or posedge reset)
    if (reset)
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    else if (we_i && waddr_i != '0)
      regs_q[waddr_i] <= wdata_i;
  assign rdata1_o = raddr1_i == '0 ? '0 : regs_q[raddr1_i];
  assign rdata2_o = raddr2_i == '0 ? '0 : regs_q[raddr2_i];
  assign dbg_data_o = dbg_addr_i == '0 ? '0 : regs_q[dbg_addr_i];
endmodule

// File: rtl/alu_issue.sv
// alu_issue: single-issue execute stage; reads operands, drives the registered ALU, writes the result back
//   clk, reset (async, active high); bus: alu_issue_if.slave carrying instruction, ALU, writeback and debug signals
module alu_issue import alu_issue_pkg::*; #(
  parameter int WORD_SIZE = DEF_WORD_SIZE,
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int REG_BITS = DEF_REG_BITS
) (
  input logic clk,
  input logic reset,
  alu_issue_if.slave bus
);
  state_e state_q, state_d;
  logic accept, write;
  logic [2:0] op_q, op_d;
  logic [WORD_SIZE-1:0] in1_q, in1_d, in2_q, in2_d, wb_data_q, wb_data_d, rs1_data, rs2_data;
  logic [REG_BITS-1:0] rd_q, rd_d, wb_rd_q, wb_rd_d;
  logic wb_valid_q, wb_valid_d;
  alu_regfile #(.WORD_SIZE(WORD_SIZE), .NUM_REGS(NUM_REGS), .REG_BITS(REG_BITS)) u_rf (
    .clk(clk),
    .reset(reset),
    .we_i(write),
    .waddr_i(rd_q),
    .wdata_i(bus.alu_out),
    .raddr1_i(bus.instr_rs1),
    .rdata1_o(rs1_data),
    .raddr2_i(bus.instr_rs2),
    .rdata2_o(rs2_data),
    .dbg_addr_i(bus.dbg_addr),
    .dbg_data_o(bus.dbg_data)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) state_q <= IDLE;
    else state_q <= state_d;
  always_comb begin
    accept = state_q == IDLE && bus.instr_valid;
    write = state_q == WRITE;
    state_d = accept ? EXEC : state_q == EXEC ? WRITE : IDLE;
    op_d = accept ? bus.instr_op : op_q;
    in1_d = accept ? rs1_data : in1_q;
    in2_d = accept ? (bus.instr_use_imm ? bus.instr_imm : rs2_data) : in2_q;
    rd_d = accept ? bus.instr_rd : rd_q;
    wb_valid_d = write;
    wb_rd_d = write ? rd_q : wb_rd_q;
    wb_data_d = write ? bus.alu_out : wb_data_q;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      op_q <= '0;
      in1_q <= '0;
      in2_q <= '0;
      rd_q <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q <= '0;
      wb_data_q <= '0;
    end else begin
      op_q <= op_d;
      in1_q <= in1_d;
      in2_q <= in2_d;
      rd_q <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q <= wb_rd_d;
      wb_data_q <= wb_data_d;
    end
  assign bus.instr_ready = state_q == IDLE;
  assign bus.alu_enable = state_q == EXEC;
  assign bus.alu_op = op_q;
  assign bus.alu_in1 = in1_q;
  assign bus.alu_in2 = in2_q;
  assign bus.wb_valid = wb_valid_q;
  assign bus.wb_rd = wb_rd_q;
  assign bus.wb_data = wb_data_q;
endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench for alu_issue with a registered ALU model attached
module tb_alu_issue;
  import alu_issue_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [18:0] exp_q [$];
  alu_issue_if bus ();
  alu_issue dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [15:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a * b;
      3'd3: return ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
      3'd4: return a & b;
      3'd5: return a | b;
      3'd6: return a ^ b;
      default: return a << b[3:0];
    endcase
  endfunction
  always_ff @(posedge clk or posedge reset)
    if (reset) bus.alu_out <= '0;
    else if (bus.alu_enable) bus.alu_out <= alu_f(bus.alu_op, bus.alu_in1, bus.alu_in2);
  always @(negedge clk)
    if (bus.wb_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected: got rd=%0d data=%h, required no writeback", bus.wb_rd, bus.wb_data);
      end else begin
        logic [18:0] e;
        e = exp_q.pop_front();
        if ({bus.wb_rd, bus.wb_data} !== e) begin
          errors++;
          $display("FAIL wb: got rd=%0d data=%h, required rd=%0d data=%h", bus.wb_rd, bus.wb_data, e[18:16], e[15:0]);
        end
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask
  task automatic drive(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                       input logic ui, input logic [15:0] imm);
    bus.instr_op = op;
    bus.instr_rd = rd;
    bus.instr_rs1 = rs1;
    bus.instr_rs2 = rs2;
    bus.instr_use_imm = ui;
    bus.instr_imm = imm;
    bus.instr_valid = 1'b1;
  endtask
  task automatic wait_accept(output int at);
    int n = 0;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.instr_ready) begin
      errors++;
      $display("FAIL accept_timeout: instr_ready stayed 0, required 1");
    end
    @(posedge clk);
    #1;
    at = cyc;
  endtask
  task automatic wait_wb();
    int n = 0;
    while (exp_q.size() != 0 && n < 12) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL wb_timeout: %0d writebacks pending, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic send(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1, input logic [2:0] rs2,
                      input logic ui, input logic [15:0] imm, input logic [15:0] exp);
    int at;
    exp_q.push_back({rd, exp});
    drive(op, rd, rs1, rs2, ui, imm);
    wait_accept(at);
    bus.instr_valid = 1'b0;
  endtask
  task automatic dbg(input logic [2:0] a, input logic [15:0] exp);
    bus.dbg_addr = a;
    #1;
    chk($sformatf("dbg_r%0d", a), bus.dbg_data, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end
  initial begin
    int acc [3];
    int a;
    bus.instr_valid = 1'b0;
    bus.instr_op = '0;
    bus.instr_rd = '0;
    bus.instr_rs1 = '0;
    bus.instr_rs2 = '0;
    bus.instr_use_imm = 1'b0;
    bus.instr_imm = '0;
    bus.dbg_addr = '0;
    #1;
    chk("rst_ready", bus.instr_ready, 1);
    chk("rst_enable", bus.alu_enable, 0);
    chk("rst_wb", {bus.wb_valid, bus.wb_rd, bus.wb_data}, 0);
    chk("rst_alu", {bus.alu_op, bus.alu_in1, bus.alu_in2}, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    send(ALU_ADD, 1, 0, 0, 1, 16'd5, 16'd5);
    @(negedge clk);
    chk("t1_exec_ready", bus.instr_ready, 0);
    chk("t1_exec_enable", bus.alu_enable, 1);
    chk("t1_exec_ops", {bus.alu_op, bus.alu_in1, bus.alu_in2}, {3'd0, 16'd0, 16'd5});
    @(negedge clk);
    chk("t1_write_ready", bus.instr_ready, 0);
    chk("t1_write_enable", bus.alu_enable, 0);
    chk("t1_write_wbv", bus.wb_valid, 0);
    @(negedge clk);
    chk("t1_idle_ready", bus.instr_ready, 1);
    chk("t1_idle_wbv", bus.wb_valid, 1);
    chk("t1_idle_enable", bus.alu_enable, 0);
    wait_wb();
    dbg(1, 16'd5);
    send(ALU_ADD, 2, 1, 0, 1, 16'd3, 16'd8);
    wait_wb();
    send(ALU_SUB, 3, 2, 1, 0, 16'd0, 16'd3);
    wait_wb();
    send(ALU_MUL, 4, 2, 3, 0, 16'd0, 16'd24);
    wait_wb();
    send(ALU_SLT, 5, 1, 2, 0, 16'd0, 16'd1);
    wait_wb();
    send(ALU_SHIFT, 6, 2, 0, 1, 16'd2, 16'd32);
    wait_wb();
    dbg(4, 16'd24);
    dbg(6, 16'd32);
    send(ALU_ADD, 0, 0, 0, 1, 16'd7, 16'd7);
    wait_wb();
    dbg(0, 16'd0);
    send(ALU_ADD, 1, 0, 0, 1, 16'd0, 16'd0);
    wait_wb();
    dbg(1, 16'd0);
    exp_q.push_back({3'd7, 16'd10});
    exp_q.push_back({3'd7, 16'd11});
    exp_q.push_back({3'd6, 16'h010B});
    drive(ALU_ADD, 7, 0, 0, 1, 16'd10);
    wait_accept(acc[0]);
    drive(ALU_ADD, 7, 7, 0, 1, 16'd1);
    wait_accept(acc[1]);
    drive(ALU_OR, 6, 7, 0, 1, 16'h0100);
    wait_accept(acc[2]);
    bus.instr_valid = 1'b0;
    chk("hs_gap1", acc[1] - acc[0], 3);
    chk("hs_gap2", acc[2] - acc[1], 3);
    wait_wb();
    send(ALU_XOR, 5, 6, 4, 0, 16'd0, 16'h0113);
    wait_wb();
    send(ALU_AND, 3, 6, 7, 0, 16'd0, 16'h000B);
    wait_wb();
    drive(ALU_ADD, 2, 2, 0, 1, 16'd1);
    wait_accept(a);
    bus.instr_valid = 1'b0;
    chk("mid_enable_before", bus.alu_enable, 1);
    reset = 1'b1;
    #1;
    chk("mid_enable", bus.alu_enable, 0);
    chk("mid_ready", bus.instr_ready, 1);
    chk("mid_wbv", bus.wb_valid, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 8; i++) dbg(i[2:0], 16'd0);
    @(negedge clk);
    send(ALU_ADD, 1, 0, 0, 1, 16'hFFFF, 16'hFFFF);
    wait_wb();
    send(ALU_ADD, 1, 1, 0, 1, 16'd1, 16'h0000);
    wait_wb();
    @(negedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Initiator side of the ALU interface: accepts one instruction at a time over a valid/ready handshake.
- Reads operands from a small internal register file and drives op/in1/in2/alu_enable into the registered ALU.
- Captures the ALU result one cycle later and writes it back, pulsing a writeback strobe.
- Sits between the instruction fetch/decode front end and the ALU; it is the simplest execute stage of the CPU.

Parameters:
- WORD_SIZE, 16, datapath width; must match the ALU's WORD_SIZE, taken from parameters.vh.
- NUM_REGS, 8, number of architectural registers; power of two, at least 2.
- REG_BITS, 3, register index width, equal to log2(NUM_REGS).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- instr_valid  in  1  instruction offered
- instr_ready  out  1  block can accept an instruction
- instr_op  in  3  ALU opcode
- instr_rd  in  REG_BITS  destination register
- instr_rs1  in  REG_BITS  source register 1
- instr_rs2  in  REG_BITS  source register 2
- instr_use_imm  in  1  1 selects instr_imm instead of regs[rs2] as in2
- instr_imm  in  WORD_SIZE  immediate operand
- alu_op  out  3  opcode to the ALU
- alu_in1  out  WORD_SIZE  ALU operand 1
- alu_in2  out  WORD_SIZE  ALU operand 2
- alu_enable  out  1  ALU capture strobe
- alu_out  in  WORD_SIZE  registered ALU result
- wb_valid  out  1  one-cycle writeback pulse
- wb_rd  out  REG_BITS  register written
- wb_data  out  WORD_SIZE  value written
- dbg_addr  in  REG_BITS  debug read index
- dbg_data  out  WORD_SIZE  combinational regs[dbg_addr]

Behaviour:
- Interface: one clock (clk); asynchronous, active-high reset (reset).
- Reset values: state IDLE; all registers 0; alu_op, alu_in1, alu_in2 and alu_enable 0; wb_valid, wb_rd and wb_data 0.
- Register 0 is hardwired to 0: writes to it are discarded and reads of it return 0. This applies to operand reads and to dbg_data.
- FSM states: IDLE, EXEC, WRITE.
- instr_ready = 1 only in IDLE; it is a combinational decode of state.
- IDLE: on instr_valid & instr_ready:
  - alu_op <= instr_op
  - alu_in1 <= regs[rs1]
  - alu_in2 <= use_imm ? imm : regs[rs2]
  - latch rd
  - go to EXEC
- IDLE with no valid: hold; all outputs keep their values except alu_enable and wb_valid, which are 0.
- EXEC: alu_enable = 1 for exactly this one cycle; the ALU registers its result at the closing edge; go to WRITE.
- WRITE:
  - regs[rd] <= alu_out (unless rd = 0)
  - wb_valid <= 1 for one cycle, with wb_rd = rd and wb_data = alu_out; wb_data shows the raw alu_out even when rd = 0
  - go to IDLE
- alu_op, alu_in1 and alu_in2 are registered and stable from EXEC through WRITE; they change only on accept.
- Timing: throughput is one instruction per 3 cycles. Latency from the accept edge to wb_valid high is 2 edges.
- No hazards: the next instruction is accepted only after writeback, so it reads the updated register.
- Arithmetic is entirely in the ALU; this block does no width conversion. SLT results arrive zero-extended.
- Opcodes in parameters.vh: ALU_ADD 0, SUB 1, MUL 2, SLT 3, AND 4, OR 5, XOR 6, SHIFT 7.
- instr_valid dropping while not ready: no effect. A source need not hold the instruction after the accept edge.
- Reset asserted in EXEC or WRITE:
  - immediate return to IDLE
  - no writeback occurs
  - alu_enable and wb_valid are forced to 0 asynchronously
  - the register file clears

Decomposition:
- parameters.vh: WORD_SIZE; ALU_* opcodes; localparams for the FSM state encoding (IDLE 0, EXEC 1, WRITE 2).
- One natural sub-module: alu_regfile. It has 2 combinational read ports plus a debug read port, 1 synchronous write port, the r0-zero rule, and asynchronous clear.
- The bench instantiates alu_issue with the real ALU attached.

Test Plan:
- Basic add: after reset, offer op=ADD, rd=1, rs1=0, use_imm=1, imm=5. Expect instr_ready low for 2 cycles, alu_enable high exactly 1 cycle, then wb_valid with wb_rd=1, wb_data=5, and dbg_data(1)=5.
- Register-register ops, run sequentially after test 1, checking wb_data each time:
  - r2 = r1 + imm 3 → 8
  - r3 = r2 SUB r1 → 3
  - r4 = r2 MUL r3 → 24
  - r5 = r1 SLT r2 → 1
  - r6 = r2 SHIFT imm 2 → 32
- r0 protection: op=ADD, rd=0, imm=7. Expect wb_valid=1, wb_rd=0, wb_data=7, and dbg_data(0) still 0. A following r1 = r0 + imm 0 gives 0.
- Handshake: hold instr_valid high continuously with 3 distinct instructions. Each is accepted only in IDLE, spaced exactly 3 cycles apart, with no duplicate or lost writeback.
- Reset mid-operation: assert reset during EXEC. Expect alu_enable low and instr_ready high immediately, no wb_valid pulse, and all registers reading 0 after release.
- Back-to-back dependency: r1 = 0 + 0xFFFF, then r1 = r1 + 1. Expect wrap to 0x0000 with WORD_SIZE=16.
